// File: rtl/aes_pkg.sv
//------------------------------------------------------------------------------
// Module   : aes_pkg
// Purpose  : Shared AES-128 types, round constants and GF(2^8) helper functions.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package aes_pkg;

  localparam int NR = 10;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] state_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fsm_t;

  function automatic byte_t get_rcon(input logic [3:0] n);
    byte_t r;
    case (n)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gf_mul(input byte_t a, input byte_t b);
    byte_t p;
    byte_t x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Column bytes are big-endian within the word: w[31:24] is row 0.
  function automatic word_t mix_column(input word_t w);
    byte_t s0, s1, s2, s3;
    s0 = w[31:24];
    s1 = w[23:16];
    s2 = w[15:8];
    s3 = w[7:0];
    return {xtime(s0) ^ xtime(s1) ^ s1 ^ s2 ^ s3,
            s0 ^ xtime(s1) ^ xtime(s2) ^ s2 ^ s3,
            s0 ^ s1 ^ xtime(s2) ^ xtime(s3) ^ s3,
            xtime(s0) ^ s0 ^ s1 ^ s2 ^ xtime(s3)};
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_sbox.sv
//------------------------------------------------------------------------------
// Module   : aes_sbox
// Purpose  : Combinational AES S-box: GF(2^8) inverse (a^254) then affine map.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_a,
  output logic [7:0] o_s
);

  byte_t w_pow;
  byte_t w_inv;

  // a^254 = a^2 * a^4 * ... * a^128; zero maps to zero as required.
  always_comb begin
    w_pow = i_a;
    w_inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      w_pow = gf_mul(w_pow, w_pow);
      w_inv = gf_mul(w_inv, w_pow);
    end
  end

  assign o_s = w_inv
             ^ {w_inv[6:0], w_inv[7]}
             ^ {w_inv[5:0], w_inv[7:6]}
             ^ {w_inv[4:0], w_inv[7:5]}
             ^ {w_inv[3:0], w_inv[7:4]}
             ^ 8'h63;

endmodule

`default_nettype wire

// File: rtl/aes_cipher_top.sv
//------------------------------------------------------------------------------
// Module   : aes_cipher_top
// Purpose  : Iterative AES-128 encryptor, one round per enabled clk edge,
//            on-the-fly key schedule. Option macro: AES_DIVCLK_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module aes_cipher_top
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         divclk,
  input  logic         ld,
  output logic         done,
  input  logic [127:0] key,
  input  logic [127:0] text_in,
  output logic [127:0] text_out
);

  state_t     r_state;
  state_t     r_rk;
  logic [3:0] r_rcnt;
  fsm_t       r_fsm;
  logic       r_done;
  state_t     r_text_out;

  logic       w_en;
  state_t     w_sb;
  state_t     w_sr;
  state_t     w_mix;
  word_t      w_rot;
  word_t      w_subrot;
  word_t      w_k0, w_k1, w_k2, w_k3;
  state_t     w_next_rk;

`ifdef AES_DIVCLK_EN
  assign w_en = divclk;
`else
  logic w_unused_divclk;
  assign w_unused_divclk = divclk;
  assign w_en = 1'b1;
`endif

  generate
    for (genvar g = 0; g < 16; g++) begin : g_state_sbox
      aes_sbox u_sbox (
        .i_a (r_state[127-8*g -: 8]),
        .o_s (w_sb[127-8*g -: 8])
      );
    end
  endgenerate

  assign w_rot = {r_rk[23:0], r_rk[31:24]};

  generate
    for (genvar g = 0; g < 4; g++) begin : g_key_sbox
      aes_sbox u_sbox (
        .i_a (w_rot[31-8*g -: 8]),
        .o_s (w_subrot[31-8*g -: 8])
      );
    end
  endgenerate

  assign w_k0      = r_rk[127:96] ^ w_subrot ^ {get_rcon(r_rcnt), 24'h0};
  assign w_k1      = r_rk[95:64]  ^ w_k0;
  assign w_k2      = r_rk[63:32]  ^ w_k1;
  assign w_k3      = r_rk[31:0]   ^ w_k2;
  assign w_next_rk = {w_k0, w_k1, w_k2, w_k3};

  // Byte n of the state is row n%4, column n/4; row r rotates left by r columns.
  always_comb begin
    w_sr  = '0;
    w_mix = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_sr[127-8*(4*c+r) -: 8] = w_sb[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      w_mix[127-32*c -: 32] = mix_column(w_sr[127-32*c -: 32]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= '0;
      r_rk       <= '0;
      r_rcnt     <= '0;
      r_fsm      <= ST_IDLE;
      r_done     <= 1'b0;
      r_text_out <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_en) begin
        if (ld) begin
          r_state <= text_in ^ key;
          r_rk    <= key;
          r_rcnt  <= 4'd1;
          r_fsm   <= ST_RUN;
        end else if (r_fsm == ST_RUN) begin
          r_rk   <= w_next_rk;
          r_rcnt <= r_rcnt + 4'd1;
          if (r_rcnt == 4'(NR)) begin
            r_text_out <= w_sr ^ w_next_rk;
            r_done     <= 1'b1;
            r_fsm      <= ST_IDLE;
          end else begin
            r_state <= w_mix ^ w_next_rk;
          end
        end
      end
    end
  end

  assign done     = r_done;
  assign text_out = r_text_out;

endmodule

`default_nettype wire

// File: tb/tb_aes_cipher_top.sv
//------------------------------------------------------------------------------
// Module   : tb_aes_cipher_top
// Purpose  : Self-checking bench for aes_cipher_top with a byte-array AES model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_aes_cipher_top;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K3 = 128'hcafebabedeadbeefdeadbeef00000000;
  localparam logic [127:0] P3 = 128'hdbe17f0684546c5571d034433d9a94b7;

  logic         clk = 1'b0;
  logic         divclk = 1'b0;
  logic         reset;
  logic         ld;
  logic         done;
  logic [127:0] key;
  logic [127:0] text_in;
  logic [127:0] text_out;

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;

  logic [7:0] sb [256];

  aes_cipher_top u_dut (
    .clk      (clk),
    .reset    (reset),
    .divclk   (divclk),
    .ld       (ld),
    .done     (done),
    .key      (key),
    .text_in  (text_in),
    .text_out (text_out)
  );

  always #5  clk    = ~clk;
  always #10 divclk = ~divclk;

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = (x[7]) ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // Reference AES-128: full 44-word expansion, byte-array state.
  function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
    logic [31:0] w [44];
    logic [7:0]  st [16];
    logic [7:0]  tmp [16];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int n = 0; n < 16; n++) st[n] = p[127-8*n -: 8] ^ k[127-8*n -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int n = 0; n < 16; n++) st[n] = sb[st[n]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          tmp[4*c+r] = st[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++) begin
        if (rnd < 10) begin
          st[4*c+0] = gm(tmp[4*c], 2) ^ gm(tmp[4*c+1], 3) ^ tmp[4*c+2] ^ tmp[4*c+3];
          st[4*c+1] = tmp[4*c] ^ gm(tmp[4*c+1], 2) ^ gm(tmp[4*c+2], 3) ^ tmp[4*c+3];
          st[4*c+2] = tmp[4*c] ^ tmp[4*c+1] ^ gm(tmp[4*c+2], 2) ^ gm(tmp[4*c+3], 3);
          st[4*c+3] = gm(tmp[4*c], 3) ^ tmp[4*c+1] ^ tmp[4*c+2] ^ gm(tmp[4*c+3], 2);
        end else begin
          for (int r = 0; r < 4; r++) st[4*c+r] = tmp[4*c+r];
        end
        for (int r = 0; r < 4; r++) st[4*c+r] = st[4*c+r] ^ w[4*rnd+c][31-8*r -: 8];
      end
    end
    for (int n = 0; n < 16; n++) res[127-8*n -: 8] = st[n];
    return res;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Output model: ld restarts a 10-edge countdown; reset clears everything.
  int           pend = 0;
  logic [127:0] pend_ct = '0;
  logic [127:0] exp_out = '0;
  logic         exp_done = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      pend     <= 0;
      exp_out  <= '0;
      exp_done <= 1'b0;
    end else begin
      exp_done <= 1'b0;
      if (ld) begin
        pend    <= 10;
        pend_ct <= aes_ref(key, text_in);
      end else if (pend > 0) begin
        if (pend == 1) begin
          exp_done <= 1'b1;
          exp_out  <= pend_ct;
        end
        pend <= pend - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("done_vs_model", {127'b0, done}, {127'b0, exp_done});
      chk("text_out_vs_model", text_out, exp_out);
    end
  end

  task automatic start(input logic [127:0] k, input logic [127:0] p);
    @(negedge clk);
    ld = 1'b1;
    key = k;
    text_in = p;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 40);
  endtask

  task automatic count_done(input int ncyc, output int nd);
    nd = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
  endtask

  initial begin
    int cyc;
    int nd;
    int first;
    logic [7:0] inv;
    reset   = 1'b0;
    ld      = 1'b0;
    key     = '0;
    text_in = '0;

    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end

    chk("model_sbox_00", {120'b0, sb[0]}, 128'h63);
    chk("model_sbox_53", {120'b0, sb[8'h53]}, 128'hed);
    chk("model_C1", aes_ref(K1, P1), C1);
    chk("model_B", aes_ref(KB, PB), CB);

    repeat (3) @(negedge clk);
    chk("reset_text_out", text_out, '0);
    chk("reset_done", {127'b0, done}, '0);
    chk_en = 1'b1;
    reset  = 1'b1;

    start(K1, P1);
    wait_done(cyc);
    chk("C1_latency", 128'(cyc), 128'd10);
    chk("C1_ct", text_out, C1);
    @(negedge clk);
    chk("C1_done_one_cycle", {127'b0, done}, '0);

    start(KB, PB);
    wait_done(cyc);
    chk("B_latency", 128'(cyc), 128'd10);
    chk("B_ct", text_out, CB);

    start(K3, P3);
    wait_done(cyc);
    chk("K3_ct", text_out, aes_ref(K3, P3));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("K3_hold", text_out, aes_ref(K3, P3));
      chk("K3_done_low", {127'b0, done}, '0);
    end

    start(K1, P1);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("midreset_text_out", text_out, '0);
    count_done(15, nd);
    chk("midreset_no_done", 128'(nd), '0);
    start(KB, PB);
    wait_done(cyc);
    chk("after_reset_B_ct", text_out, CB);
    chk("after_reset_latency", 128'(cyc), 128'd10);

    start(KB, PB);
    repeat (3) @(negedge clk);
    start(K1, P1);
    nd = 0;
    first = 0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (first == 0) first = i;
        chk("repulse_ct", text_out, C1);
      end
    end
    chk("repulse_single_done", 128'(nd), 128'd1);
    chk("repulse_latency", 128'(first), 128'd10);

    @(negedge clk);
    ld = 1'b1;
    key = K1;
    text_in = PB;
    count_done(6, nd);
    ld = 1'b0;
    chk("held_ld_no_done", 128'(nd), '0);
    wait_done(cyc);
    chk("held_release_latency", 128'(cyc), 128'd10);
    chk("held_release_ct", text_out, aes_ref(K1, PB));

    @(negedge clk);
    reset = 1'b0;
    ld = 1'b1;
    key = KB;
    text_in = PB;
    @(negedge clk);
    reset = 1'b1;
    ld = 1'b0;
    count_done(15, nd);
    chk("ld_with_reset_no_done", 128'(nd), '0);
    chk("ld_with_reset_text_out", text_out, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
